ma_stage: RTL and testbench
===========================

# ma_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It accepts one instruction per handshake and issues at most one data-memory transaction per instruction over a request/address-ok/data-ok bus. It builds store byte strobes and data, and aligns or merges load data. It presents a registered result to write-back and holds it stable under back-pressure.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- empty  in  1  pipeline flush (exception/eret); squashes the held instruction
- EX_ready  in  1  execute stage has a valid instruction to hand over
- MA_enable  out  1  this stage can accept an instruction this cycle
- MA_ready  out  1  this stage holds a completed instruction for write-back
- WB_enable  in  1  write-back can accept this cycle
- rf_waddr_in / rf_wen_in / rf_wdata_src_in  in  5/1/3  destination info, passed through
- mem_read_in, mem_write_in  in  1 each  load / store
- align_load_in  in  7  one-hot: [6]lw [5]lb [4]lbu [3]lh [2]lhu [1]lwl [0]lwr
- align_store_in  in  5  one-hot: [4]sw [3]sb [2]sh [1]swl [0]swr
- alu_res_in  in  32  effective address or ALU/link result
- rf_B_in  in  32  rt value (store data, lwl/lwr merge source)
- EX_PC  in  32  instruction PC
- exccode_in  in  5  nonzero = exception already detected
- rf_waddr_out, rf_wen_out, rf_wdata_src_out, MA_PC, exccode_out  out  —  registered pass-through
- rf_wdata_out  out  32  load result if load, else alu_res
- data_req, data_wr  out  1 each  bus request / write
- data_size  out  2  0=byte 1=half 2=word
- data_addr  out  32  byte address; word-aligned for lwl/lwr/swl/swr
- data_wstrb  out  4  byte enables
- data_wdata  out  32  store data
- data_addr_ok, data_data_ok  in  1 each  address accepted / data returned
- data_rdata  in  32  load data
- valid_out  out  1  stage holds an instruction (for forwarding)

## Operation
- Accept when MA_enable && EX_ready: latch all inputs and set valid. MA_enable = !valid || (MA_ready && WB_enable), and it is forced to 0 in DRAIN.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- On accept, a memory op (read or write) with exccode_in==0 goes to REQ; otherwise the stage goes to DONE.
- REQ: data_req=1 with stable fields. On data_addr_ok go to WAIT.
- WAIT: on data_data_ok, register the result and go to DONE.
- DONE: MA_ready=1. On MA_ready && WB_enable, go to IDLE, or take the new instruction if one is accepted in the same cycle.
- Store strobes (a=addr[1:0], little-endian):
  - sb: strb 1<<a, wdata {4{rt[7:0]}}.
  - sh: strb a[1]?1100:0011, wdata {2{rt[15:0]}}.
  - sw: strb 1111.
  - swl: strb 0001/0011/0111/1111, wdata rt>>(24-8a).
  - swr: strb 1111/1110/1100/1000, wdata rt<<8a.
- Loads:
  - lb/lbu/lh/lhu: select the byte/half at a, sign- or zero-extend.
  - lwl: result = (rdata<<(24-8a)) | (rt & (32'hFFFFFF>>8a)).
  - lwr: result = (rdata>>8a) | (rt & ~(32'hFFFFFFFF>>8a)).
- Stores and excepted instructions: rf_wdata_out = alu_res.
- Flush (empty=1):
  - Clears valid.
  - From IDLE/REQ/DONE: go to IDLE and drop data_req immediately.
  - From WAIT: go to DRAIN, hold MA_enable=0, discard the data_data_ok beat, then go to IDLE.

## Timing
- Reset values: valid=0, state IDLE, MA_ready=0, data_req=0, data_wr=0, data_wstrb=0, and all registered outputs 0. MA_enable=1 after reset.
- Non-memory or excepted instruction: MA_ready in the cycle after acceptance (latency 1).
- Memory op: data_req rises in the cycle after acceptance. data_data_ok arrives no earlier than the cycle after data_addr_ok. MA_ready rises the cycle after data_data_ok.
- Outputs hold stable while MA_ready && !WB_enable.
- At most one outstanding transaction. No new data_req while in WAIT or DRAIN.
- empty has priority over acceptance in the same cycle.
- Reset mid-transaction clears everything immediately. The bus is also reset.

## Test plan
- Back-to-back ALU ops, WB_enable=1 → one result per cycle; rf_wdata_out = alu_res_in, latency 1.
- sb rt=0x11223344, addr 0x1002 → data_wstrb=0100, data_wdata=0x44444444, data_size=0; MA_ready one cycle after data_data_ok.
- lh addr 0x2002, rdata 0x8001ABCD → rf_wdata_out=0xFFFF8001. lhu at the same address → 0x00008001.
- lwl addr 0x3001, rdata 0xAABBCCDD, rt 0x11223344 → 0xCCDD3344. lwr at the same address → 0x11AABBCC.
- Load with exccode_in=0x04 → no data_req; MA_ready next cycle with exccode_out=0x04.
- empty asserted in WAIT, data_data_ok 3 cycles later → MA_enable=0 until that beat, no MA_ready, then a new instruction is accepted normally.

Source files
------------

// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage between execute and write-back.
// Ports: EX handshake (EX_ready/MA_enable) and destination/operand inputs,
//   WB handshake (MA_ready/WB_enable) with registered pass-through outputs,
//   data bus (data_req/wr/size/addr/wstrb/wdata, addr_ok/data_ok/rdata),
//   empty flushes the held instruction, valid_out feeds forwarding.
module ma_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        empty,
    input  logic        EX_ready,
    output logic        MA_enable,
    output logic        MA_ready,
    input  logic        WB_enable,
    input  logic [4:0]  rf_waddr_in,
    input  logic        rf_wen_in,
    input  logic [2:0]  rf_wdata_src_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [6:0]  align_load_in,
    input  logic [4:0]  align_store_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] rf_B_in,
    input  logic [31:0] EX_PC,
    input  logic [4:0]  exccode_in,
    output logic [4:0]  rf_waddr_out,
    output logic        rf_wen_out,
    output logic [2:0]  rf_wdata_src_out,
    output logic [31:0] MA_PC,
    output logic [4:0]  exccode_out,
    output logic [31:0] rf_wdata_out,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        valid_out
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic        valid_q;
    logic [4:0]  waddr_q, exc_q;
    logic        wen_q, rd_q, wr_q;
    logic [2:0]  wsrc_q;
    logic [6:0]  ld_q;
    logic [4:0]  st_q;
    logic [31:0] addr_q, rt_q, pc_q, res_q;

    logic        accept, retire, is_mem;
    logic [1:0]  a;
    logic [4:0]  sh;
    logic [31:0] rsh, load_res, st_data;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [3:0]  st_strb;

    assign MA_ready  = (state_q == S_DONE);
    assign retire    = MA_ready && WB_enable;
    assign MA_enable = (state_q != S_DRAIN) && (!valid_q || retire);
    // flush wins over a simultaneous hand-over
    assign accept    = MA_enable && EX_ready && !empty;
    assign is_mem    = (mem_read_in || mem_write_in) && (exccode_in == 5'd0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = is_mem ? S_REQ : S_DONE;
            S_REQ: begin
                if (empty)             state_d = S_IDLE;
                else if (data_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                // a beat coinciding with the flush is itself the discarded one
                if (data_data_ok) state_d = empty ? S_IDLE : S_DONE;
                else if (empty)   state_d = S_DRAIN;
            end
            S_DONE: begin
                if (empty)       state_d = S_IDLE;
                else if (accept) state_d = is_mem ? S_REQ : S_DONE;
                else if (retire) state_d = S_IDLE;
            end
            S_DRAIN: if (data_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign a     = addr_q[1:0];
    assign sh    = {a, 3'b000};
    assign rsh   = data_rdata >> sh;
    assign lbyte = rsh[7:0];
    assign lhalf = a[1] ? data_rdata[31:16] : data_rdata[15:0];

    always_comb begin
        load_res = data_rdata;
        case (1'b1)
            ld_q[5]: load_res = {{24{lbyte[7]}}, lbyte};
            ld_q[4]: load_res = {24'd0, lbyte};
            ld_q[3]: load_res = {{16{lhalf[15]}}, lhalf};
            ld_q[2]: load_res = {16'd0, lhalf};
            ld_q[1]: load_res = (data_rdata << (5'd24 - sh))
                              | (rt_q & (32'h00FF_FFFF >> sh));
            ld_q[0]: load_res = (data_rdata >> sh)
                              | (rt_q & ~(32'hFFFF_FFFF >> sh));
            default: load_res = data_rdata;
        endcase
    end

    always_comb begin
        st_strb = 4'b0000;
        st_data = rt_q;
        case (1'b1)
            st_q[4]: st_strb = 4'b1111;
            st_q[3]: begin
                st_strb = 4'b0001 << a;
                st_data = {4{rt_q[7:0]}};
            end
            st_q[2]: begin
                st_strb = a[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rt_q[15:0]}};
            end
            st_q[1]: begin
                st_strb = 4'b1111 >> (2'd3 - a);
                st_data = rt_q >> (5'd24 - sh);
            end
            st_q[0]: begin
                st_strb = 4'b1111 << a;
                st_data = rt_q << sh;
            end
            default: st_strb = 4'b0000;
        endcase
    end

    always_comb begin
        data_size = 2'd2;
        if (ld_q[5] || ld_q[4] || st_q[3])      data_size = 2'd0;
        else if (ld_q[3] || ld_q[2] || st_q[2]) data_size = 2'd1;
    end

    // partial-word lwl/lwr/swl/swr always address the containing word
    assign data_addr  = (ld_q[1] || ld_q[0] || st_q[1] || st_q[0])
                      ? {addr_q[31:2], 2'b00} : addr_q;
    assign data_req   = (state_q == S_REQ) && !empty;
    assign data_wr    = data_req && wr_q;
    assign data_wstrb = wr_q ? st_strb : 4'b0000;
    assign data_wdata = st_data;

    assign rf_waddr_out     = waddr_q;
    assign rf_wen_out       = wen_q;
    assign rf_wdata_src_out = wsrc_q;
    assign MA_PC            = pc_q;
    assign exccode_out      = exc_q;
    assign rf_wdata_out     = res_q;
    assign valid_out        = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            waddr_q <= '0;
            wen_q   <= 1'b0;
            wsrc_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ld_q    <= '0;
            st_q    <= '0;
            addr_q  <= '0;
            rt_q    <= '0;
            pc_q    <= '0;
            exc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (empty)       valid_q <= 1'b0;
            else if (accept) valid_q <= 1'b1;
            else if (retire) valid_q <= 1'b0;
            if (accept) begin
                waddr_q <= rf_waddr_in;
                wen_q   <= rf_wen_in;
                wsrc_q  <= rf_wdata_src_in;
                rd_q    <= mem_read_in;
                wr_q    <= mem_write_in;
                ld_q    <= align_load_in;
                st_q    <= align_store_in;
                addr_q  <= alu_res_in;
                rt_q    <= rf_B_in;
                pc_q    <= EX_PC;
                exc_q   <= exccode_in;
                res_q   <= alu_res_in;
            end else if (state_q == S_WAIT && data_data_ok
                         && rd_q && !empty) begin
                res_q <= load_res;
            end
        end
    end
endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: self-checking bench for ma_stage with a byte-level
// reference model of loads/stores and a simple bus responder.
module tb_ma_stage;
    logic        clk = 1'b0, rst_n = 1'b0, empty = 1'b0;
    logic        EX_ready = 1'b0, WB_enable = 1'b1;
    logic        MA_enable, MA_ready;
    logic [4:0]  rf_waddr_in = '0;
    logic        rf_wen_in = 1'b0;
    logic [2:0]  rf_wdata_src_in = '0;
    logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic [6:0]  align_load_in = '0;
    logic [4:0]  align_store_in = '0;
    logic [31:0] alu_res_in = '0, rf_B_in = '0, EX_PC = '0;
    logic [4:0]  exccode_in = '0;
    logic [4:0]  rf_waddr_out, exccode_out;
    logic        rf_wen_out;
    logic [2:0]  rf_wdata_src_out;
    logic [31:0] MA_PC, rf_wdata_out;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    ma_stage dut (
        .clk(clk), .rst_n(rst_n), .empty(empty),
        .EX_ready(EX_ready), .MA_enable(MA_enable),
        .MA_ready(MA_ready), .WB_enable(WB_enable),
        .rf_waddr_in(rf_waddr_in), .rf_wen_in(rf_wen_in),
        .rf_wdata_src_in(rf_wdata_src_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .align_load_in(align_load_in),
        .align_store_in(align_store_in),
        .alu_res_in(alu_res_in), .rf_B_in(rf_B_in),
        .EX_PC(EX_PC), .exccode_in(exccode_in),
        .rf_waddr_out(rf_waddr_out), .rf_wen_out(rf_wen_out),
        .rf_wdata_src_out(rf_wdata_src_out), .MA_PC(MA_PC),
        .exccode_out(exccode_out), .rf_wdata_out(rf_wdata_out),
        .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [6:0] ld, input logic [4:0] st,
                         input logic [31:0] alu, input logic [31:0] rt,
                         input logic [31:0] pc, input logic [4:0] exc,
                         input logic [4:0] wa);
        mem_read_in     = rd;
        mem_write_in    = wr;
        align_load_in   = ld;
        align_store_in  = st;
        alu_res_in      = alu;
        rf_B_in         = rt;
        EX_PC           = pc;
        exccode_in      = exc;
        rf_waddr_in     = wa;
        rf_wen_in       = rd;
        rf_wdata_src_in = pc[2:0];
        EX_ready        = 1'b1;
    endtask

    // k: 6 lw 5 lb 4 lbu 3 lh 2 lhu 1 lwl 0 lwr
    function automatic logic [31:0] load_model(int k, int ai,
                                               logic [31:0] rd,
                                               logic [31:0] rt);
        logic [7:0] mb [4];
        logic [7:0] rb [4];
        int v;
        for (int i = 0; i < 4; i++) begin
            mb[i] = 8'(rd >> (8 * i));
            rb[i] = 8'(rt >> (8 * i));
        end
        case (k)
            5: begin
                v = int'(mb[ai]);
                if (v > 127) v -= 256;
                return 32'(v);
            end
            4: return 32'(mb[ai]);
            3: begin
                v = int'(mb[ai + 1]) * 256 + int'(mb[ai]);
                if (v > 32767) v -= 65536;
                return 32'(v);
            end
            2: return 32'(int'(mb[ai + 1]) * 256 + int'(mb[ai]));
            1: begin
                for (int j = 0; j <= ai; j++) rb[3 - ai + j] = mb[j];
                return {rb[3], rb[2], rb[1], rb[0]};
            end
            0: begin
                for (int j = ai; j < 4; j++) rb[j - ai] = mb[j];
                return {rb[3], rb[2], rb[1], rb[0]};
            end
            default: return rd;
        endcase
    endfunction

    // k: 4 sw 3 sb 2 sh 1 swl 0 swr
    function automatic logic [35:0] store_model(int k, int ai,
                                                logic [31:0] rt);
        logic [3:0]  s;
        logic [31:0] w;
        case (k)
            3: begin
                s = 4'(1 << ai);
                w = {24'd0, rt[7:0]} * 32'h0101_0101;
            end
            2: begin
                s = (ai >= 2) ? 4'hC : 4'h3;
                w = {16'd0, rt[15:0]} * 32'h0001_0001;
            end
            1: begin
                s = 4'((1 << (ai + 1)) - 1);
                w = rt >> (24 - 8 * ai);
            end
            0: begin
                s = 4'((15 << ai) & 15);
                w = rt << (8 * ai);
            end
            default: begin
                s = 4'hF;
                w = rt;
            end
        endcase
        return {s, w};
    endfunction

    function automatic logic [1:0] size_model(logic is_ld, int k);
        if (is_ld) return (k == 5 || k == 4) ? 2'd0
                        : (k == 3 || k == 2) ? 2'd1 : 2'd2;
        return (k == 3) ? 2'd0 : (k == 2) ? 2'd1 : 2'd2;
    endfunction

    task automatic mem_op(input logic is_ld, input int k,
                          input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input int dly,
                          output logic ok, output int waits,
                          output logic [31:0] o_addr,
                          output logic [31:0] o_wdata,
                          output logic [3:0] o_strb,
                          output logic [1:0] o_size, output logic o_wr,
                          output logic early, output logic rdy,
                          output logic [31:0] res);
        logic [6:0] ld;
        logic [4:0] st;
        ld = '0;
        st = '0;
        if (is_ld) ld[k] = 1'b1;
        else       st[k] = 1'b1;
        drive(is_ld, !is_ld, ld, st, addr, rt, $urandom, 5'd0,
              5'($urandom));
        step();
        EX_ready = 1'b0;
        ok = 1'b0;
        waits = 0;
        early = 1'b0;
        rdy = 1'b0;
        res = '0;
        o_addr = '0;
        o_wdata = '0;
        o_strb = '0;
        o_size = '0;
        o_wr = 1'b0;
        while (!ok && waits < 20) begin
            if (data_req) ok = 1'b1;
            else begin
                early |= MA_ready;
                step();
                waits++;
            end
        end
        if (ok) begin
            o_addr = data_addr;
            o_wdata = data_wdata;
            o_strb = data_wstrb;
            o_size = data_size;
            o_wr = data_wr;
            data_addr_ok = 1'b1;
            step();
            data_addr_ok = 1'b0;
            for (int i = 0; i < dly; i++) begin
                early |= MA_ready;
                step();
            end
            early |= MA_ready;
            data_data_ok = 1'b1;
            data_rdata = rdata;
            step();
            data_data_ok = 1'b0;
            data_rdata = $urandom;
            rdy = MA_ready;
            res = rf_wdata_out;
            step();
        end
    endtask

    task automatic test_reset();
        checks++;
        if (MA_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_en got %b want 1", MA_enable);
        end
        checks++;
        if ({MA_ready, data_req, valid_out, data_wr} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000",
                     {MA_ready, data_req, valid_out, data_wr});
        end
        checks++;
        if (data_wstrb !== 4'b0) begin
            errors++;
            $display("FAIL reset_wstrb got %b want 0000", data_wstrb);
        end
        checks++;
        if ({rf_wdata_out, MA_PC, exccode_out, rf_waddr_out} !== '0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h %h want 0",
                     rf_wdata_out, MA_PC, exccode_out, rf_waddr_out);
        end
        #12 rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_back_to_back();
        logic [31:0] alu, pc;
        logic [4:0]  wa;
        WB_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alu = $urandom;
            pc = $urandom;
            wa = 5'($urandom);
            drive(1'b0, 1'b0, '0, '0, alu, $urandom, pc, 5'd0, wa);
            step();
            checks++;
            if (MA_ready !== 1'b1 || rf_wdata_out !== alu) begin
                errors++;
                $display("FAIL alu_b2b[%0d] got rdy=%b %h want 1 %h",
                         i, MA_ready, rf_wdata_out, alu);
            end
            checks++;
            if (MA_PC !== pc || rf_waddr_out !== wa || data_req) begin
                errors++;
                $display("FAIL alu_pass[%0d] got %h %h req=%b want %h %h",
                         i, MA_PC, rf_waddr_out, data_req, pc, wa);
            end
        end
        EX_ready = 1'b0;
        step();
        checks++;
        if (MA_ready !== 1'b0 || MA_enable !== 1'b1) begin
            errors++;
            $display("FAIL alu_drain got rdy=%b en=%b want 0 1",
                     MA_ready, MA_enable);
        end
    endtask

    task automatic test_store();
        logic ok, wr, early, rdy;
        int waits, k, ai;
        logic [31:0] addr, rt, oa, ow, res;
        logic [3:0] os;
        logic [1:0] sz;
        logic [35:0] m;
        mem_op(1'b0, 3, 32'h1002, 32'h1122_3344, $urandom, 0,
               ok, waits, oa, ow, os, sz, wr, early, rdy, res);
        checks++;
        if (!ok || waits != 0) begin
            errors++;
            $display("FAIL sb_req got ok=%b waits=%0d want 1 0", ok, waits);
        end
        checks++;
        if (os !== 4'b0100 || ow !== 32'h4444_4444 || sz !== 2'd0) begin
            errors++;
            $display("FAIL sb_bus got %b %h %0d want 0100 44444444 0",
                     os, ow, sz);
        end
        checks++;
        if (wr !== 1'b1 || oa !== 32'h1002) begin
            errors++;
            $display("FAIL sb_addr got wr=%b %h want 1 1002", wr, oa);
        end
        checks++;
        if (early || rdy !== 1'b1 || res !== 32'h1002) begin
            errors++;
            $display("FAIL sb_done got e=%b r=%b %h want 0 1 1002",
                     early, rdy, res);
        end
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 4);
            addr = $urandom;
            if (k == 2) addr[0] = 1'b0;
            if (k == 4) addr[1:0] = 2'b00;
            ai = int'(addr[1:0]);
            rt = $urandom;
            mem_op(1'b0, k, addr, rt, $urandom, $urandom_range(0, 3),
                   ok, waits, oa, ow, os, sz, wr, early, rdy, res);
            m = store_model(k, ai, rt);
            checks++;
            if (!ok || os !== m[35:32] || ow !== m[31:0]) begin
                errors++;
                $display("FAIL st_rand[%0d] k=%0d got %b %h want %b %h",
                         i, k, os, ow, m[35:32], m[31:0]);
            end
            checks++;
            if (sz !== size_model(1'b0, k) || wr !== 1'b1
                || oa !== ((k <= 1) ? (addr & ~32'd3) : addr)) begin
                errors++;
                $display("FAIL st_attr[%0d] got sz=%0d wr=%b a=%h", i,
                         sz, wr, oa);
            end
            checks++;
            if (early || rdy !== 1'b1 || res !== addr) begin
                errors++;
                $display("FAIL st_done[%0d] got %b %b %h want 0 1 %h",
                         i, early, rdy, res, addr);
            end
        end
    endtask

    task automatic test_loads();
        logic ok, wr, early, rdy;
        int waits, k;
        logic [31:0] addr, rt, rd, oa, ow, res, exp;
        logic [3:0] os;
        logic [1:0] sz;
        mem_op(1'b1, 3, 32'h2002, $urandom, 32'h8001_ABCD, 1,
               ok, waits, oa, ow, os, sz, wr, early, rdy, res);
        checks++;
        if (!rdy || res !== 32'hFFFF_8001 || sz !== 2'd1 || wr) begin
            errors++;
            $display("FAIL lh got %h sz=%0d wr=%b want ffff8001 1 0",
                     res, sz, wr);
        end
        mem_op(1'b1, 2, 32'h2002, $urandom, 32'h8001_ABCD, 0,
               ok, waits, oa, ow, os, sz, wr, early, rdy, res);
        checks++;
        if (!rdy || res !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu got %h want 00008001", res);
        end
        mem_op(1'b1, 1, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD, 2,
               ok, waits, oa, ow, os, sz, wr, early, rdy, res);
        checks++;
        if (!rdy || res !== 32'hCCDD_3344 || oa !== 32'h3000) begin
            errors++;
            $display("FAIL lwl got %h a=%h want ccdd3344 3000", res, oa);
        end
        mem_op(1'b1, 0, 32'h3001, 32'h1122_3344, 32'hAABB_CCDD, 0,
               ok, waits, oa, ow, os, sz, wr, early, rdy, res);
        checks++;
        if (!rdy || res !== 32'h11AA_BBCC) begin
            errors++;
            $display("FAIL lwr got %h want 11aabbcc", res);
        end
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 6);
            addr = $urandom;
            if (k == 3 || k == 2) addr[0] = 1'b0;
            if (k == 6) addr[1:0] = 2'b00;
            rt = $urandom;
            rd = $urandom;
            mem_op(1'b1, k, addr, rt, rd, $urandom_range(0, 3),
                   ok, waits, oa, ow, os, sz, wr, early, rdy, res);
            exp = load_model(k, int'(addr[1:0]), rd, rt);
            checks++;
            if (!ok || early || rdy !== 1'b1 || res !== exp) begin
                errors++;
                $display("FAIL ld_rand[%0d] k=%0d got %h want %h", i, k,
                         res, exp);
            end
            checks++;
            if (sz !== size_model(1'b1, k) || wr !== 1'b0
                || oa !== ((k <= 1) ? (addr & ~32'd3) : addr)) begin
                errors++;
                $display("FAIL ld_attr[%0d] got sz=%0d wr=%b a=%h", i,
                         sz, wr, oa);
            end
        end
    endtask

    task automatic test_exception();
        drive(1'b1, 1'b0, 7'b100_0000, '0, 32'h4000, $urandom,
              32'hBFC0_0010, 5'h04, 5'd3);
        step();
        EX_ready = 1'b0;
        checks++;
        if (data_req !== 1'b0 || MA_ready !== 1'b1) begin
            errors++;
            $display("FAIL exc_ctl got req=%b rdy=%b want 0 1",
                     data_req, MA_ready);
        end
        checks++;
        if (exccode_out !== 5'h04 || rf_wdata_out !== 32'h4000) begin
            errors++;
            $display("FAIL exc_out got %h %h want 04 4000",
                     exccode_out, rf_wdata_out);
        end
        step();
        checks++;
        if (data_req !== 1'b0 || MA_ready !== 1'b0) begin
            errors++;
            $display("FAIL exc_after got req=%b rdy=%b want 0 0",
                     data_req, MA_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] va, vb;
        va = $urandom;
        vb = $urandom;
        WB_enable = 1'b0;
        drive(1'b0, 1'b0, '0, '0, va, 0, 32'h100, 5'd0, 5'd1);
        step();
        drive(1'b0, 1'b0, '0, '0, vb, 0, 32'h104, 5'd0, 5'd2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!MA_ready || MA_enable || rf_wdata_out !== va
                || MA_PC !== 32'h100) begin
                errors++;
                $display("FAIL bp_hold[%0d] got r=%b e=%b %h want 1 0 %h",
                         i, MA_ready, MA_enable, rf_wdata_out, va);
            end
            step();
        end
        WB_enable = 1'b1;
        #1;
        checks++;
        if (MA_enable !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got en=%b want 1", MA_enable);
        end
        step();
        EX_ready = 1'b0;
        checks++;
        if (!MA_ready || rf_wdata_out !== vb || MA_PC !== 32'h104) begin
            errors++;
            $display("FAIL bp_next got %h want %h", rf_wdata_out, vb);
        end
        step();
    endtask

    task automatic test_flush_wait();
        logic [31:0] vc;
        int n;
        vc = $urandom;
        drive(1'b1, 1'b0, 7'b100_0000, '0, 32'h5000, 0, 0, 5'd0, 5'd4);
        step();
        EX_ready = 1'b0;
        n = 0;
        while (!data_req && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!data_req) begin
            errors++;
            $display("FAIL fl_req got no data_req want 1");
        end
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        empty = 1'b1;
        #1;
        step();
        empty = 1'b0;
        drive(1'b0, 1'b0, '0, '0, vc, 0, 32'h200, 5'd0, 5'd5);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (MA_enable || MA_ready || valid_out || data_req) begin
                errors++;
                $display("FAIL fl_drain[%0d] got e=%b r=%b v=%b q=%b",
                         i, MA_enable, MA_ready, valid_out, data_req);
            end
            step();
        end
        data_data_ok = 1'b1;
        data_rdata = $urandom;
        checks++;
        if (MA_enable !== 1'b0) begin
            errors++;
            $display("FAIL fl_beat got en=%b want 0", MA_enable);
        end
        step();
        data_data_ok = 1'b0;
        checks++;
        if (MA_enable !== 1'b1 || MA_ready !== 1'b0) begin
            errors++;
            $display("FAIL fl_idle got e=%b r=%b want 1 0",
                     MA_enable, MA_ready);
        end
        step();
        EX_ready = 1'b0;
        checks++;
        if (!MA_ready || rf_wdata_out !== vc || data_req) begin
            errors++;
            $display("FAIL fl_new got r=%b %h want 1 %h",
                     MA_ready, rf_wdata_out, vc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 7'b100_0000, '0, 32'h6000, 0, 0, 5'd0, 5'd6);
        step();
        EX_ready = 1'b0;
        checks++;
        if (data_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_req got %b want 1", data_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (data_req || valid_out || !MA_enable || rf_wdata_out !== 0) begin
            errors++;
            $display("FAIL rst_mid got q=%b v=%b e=%b %h",
                     data_req, valid_out, MA_enable, rf_wdata_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_alu_back_to_back();
        test_store();
        test_loads();
        test_exception();
        test_backpressure();
        test_flush_wait();
        test_reset_mid();
        test_alu_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
